// File: rtl/vx_wb_sched_pkg.sv
// Shared types and helpers for the writeback scheduler.
package vx_wb_sched_pkg;

   typedef enum logic [0:0] {ARB, LOCKED} wb_sched_state_e;

   // Width of a source index; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vx_wb_sched_if.sv
// Commit-source / writeback bus seen by the scheduler.
interface vx_wb_sched_if
   import vx_wb_sched_pkg::*;
#(
   parameter int unsigned NUM_REQS = 5,
   parameter int unsigned DATAW    = 32
);
   localparam int unsigned IdxW = idx_width(NUM_REQS);

   logic [NUM_REQS-1:0]       req_valid;
   logic [NUM_REQS*DATAW-1:0] req_data;
   logic [NUM_REQS-1:0]       req_eop;
   logic [NUM_REQS-1:0]       req_ready;
   logic                      out_valid;
   logic [DATAW-1:0]          out_data;
   logic                      out_eop;
   logic [IdxW-1:0]           out_grant;
   logic                      out_ready;
   logic                      starve_evt;

   // Commit sources plus the writeback sink.
   modport master (
      output req_valid, req_data, req_eop, out_ready,
      input  req_ready, out_valid, out_data, out_eop, out_grant, starve_evt
   );

   // The scheduler itself.
   modport slave (
      input  req_valid, req_data, req_eop, out_ready,
      output req_ready, out_valid, out_data, out_eop, out_grant, starve_evt
   );

endinterface

// File: rtl/vx_wb_rr_pick.sv
// Circular first-set picker: searches mask starting at position ptr, wrapping.
module vx_wb_rr_pick
   import vx_wb_sched_pkg::*;
#(
   parameter int unsigned N    = 5,
   parameter int unsigned IdxW = idx_width(N)
) (
   input  logic [N-1:0]    mask,
   input  logic [IdxW-1:0] ptr,
   output logic [N-1:0]    onehot,
   output logic [IdxW-1:0] index,
   output logic            any
);

   // Walk ptr, ptr+1, ... modulo N and take the first set bit.
   always_comb begin
      int unsigned pos;
      onehot = '0;
      index  = '0;
      any    = 1'b0;
      pos    = 0;
      for (int unsigned k = 0; k < N; k++) begin
         pos = 32'(ptr) + k;
         if (pos >= N) pos = pos - N;
         if (!any && mask[pos[IdxW-1:0]]) begin
            any                     = 1'b1;
            index                   = pos[IdxW-1:0];
            onehot[pos[IdxW-1:0]]   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vx_wb_sched.sv
// Writeback port scheduler: round-robin with starvation override, packet locking
// and a registered output stage.
module vx_wb_sched
   import vx_wb_sched_pkg::*;
#(
   parameter int unsigned NUM_REQS   = 5,
   parameter int unsigned DATAW      = 32,
   parameter int unsigned STARVE_MAX = 15,
   parameter bit          LOCK_EOP   = 1'b1
) (
   input logic          clk,
   input logic          reset,
   vx_wb_sched_if.slave bus
);

   localparam int unsigned IdxW = idx_width(NUM_REQS);
   localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

   wb_sched_state_e     state_q, state_d;
   logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IdxW-1:0]     lock_idx_q, lock_idx_d;
   logic [CntW-1:0]     wait_cnt_q [NUM_REQS];
   logic [CntW-1:0]     wait_cnt_d [NUM_REQS];

   logic [NUM_REQS-1:0] starved, rr_oh, st_oh, grant_oh;
   logic [IdxW-1:0]     rr_start, rr_idx, st_idx, grant_idx;
   logic                rr_any, st_any, grant_vld, starve_win, stage_rdy;
   logic [DATAW-1:0]    grant_data;

   logic                out_valid_q, out_eop_q, starve_q;
   logic [DATAW-1:0]    out_data_q;
   logic [IdxW-1:0]     out_grant_q;

   assign stage_rdy  = ~out_valid_q | bus.out_ready;
   // Round-robin search begins just after the last winner.
   assign rr_start   = (rr_ptr_q == IdxW'(NUM_REQS - 1)) ? '0 : rr_ptr_q + 1'b1;
   assign grant_data = bus.req_data[32'(grant_idx) * DATAW +: DATAW];

   // Sources that are valid and have waited the maximum number of cycles.
   always_comb begin
      starved = '0;
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
         starved[i] = bus.req_valid[i] && (wait_cnt_q[i] == CntW'(STARVE_MAX));
      end
   end

   vx_wb_rr_pick #(.N(NUM_REQS), .IdxW(IdxW)) u_rr_pick (
      .mask   (bus.req_valid),
      .ptr    (rr_start),
      .onehot (rr_oh),
      .index  (rr_idx),
      .any    (rr_any)
   );

   // Starting at 0 makes this a lowest-index pick among starved sources.
   vx_wb_rr_pick #(.N(NUM_REQS), .IdxW(IdxW)) u_starve_pick (
      .mask   (starved),
      .ptr    ('0),
      .onehot (st_oh),
      .index  (st_idx),
      .any    (st_any)
   );

   // Grant selection and FSM next state; a lock outranks starvation.
   always_comb begin
      state_d    = state_q;
      lock_idx_d = lock_idx_q;
      rr_ptr_d   = rr_ptr_q;
      grant_oh   = '0;
      grant_idx  = '0;
      grant_vld  = 1'b0;
      starve_win = 1'b0;
      unique case (state_q)
         ARB: begin
            if (stage_rdy) begin
               if (st_any) begin
                  grant_oh   = st_oh;
                  grant_idx  = st_idx;
                  grant_vld  = 1'b1;
                  starve_win = 1'b1;
               end else if (rr_any) begin
                  grant_oh  = rr_oh;
                  grant_idx = rr_idx;
                  grant_vld = 1'b1;
               end
               if (grant_vld && LOCK_EOP && !bus.req_eop[grant_idx]) begin
                  state_d    = LOCKED;
                  lock_idx_d = grant_idx;
               end
            end
         end
         LOCKED: begin
            if (stage_rdy && bus.req_valid[lock_idx_q]) begin
               grant_oh[lock_idx_q] = 1'b1;
               grant_idx            = lock_idx_q;
               grant_vld            = 1'b1;
               if (bus.req_eop[lock_idx_q]) state_d = ARB;
            end
         end
         default: state_d = ARB;
      endcase
      if (grant_vld) rr_ptr_d = grant_idx;
   end

   // Age counters: cleared on grant or idle, saturate while waiting (stalls included).
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
         if (grant_oh[i] || !bus.req_valid[i]) begin
            wait_cnt_d[i] = '0;
         end else if (wait_cnt_q[i] != CntW'(STARVE_MAX)) begin
            wait_cnt_d[i] = wait_cnt_q[i] + 1'b1;
         end else begin
            wait_cnt_d[i] = wait_cnt_q[i];
         end
      end
   end

   // Arbiter state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ARB;
         rr_ptr_q   <= IdxW'(NUM_REQS - 1);
         lock_idx_q <= '0;
         for (int unsigned i = 0; i < NUM_REQS; i++) wait_cnt_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         lock_idx_q <= lock_idx_d;
         for (int unsigned i = 0; i < NUM_REQS; i++) wait_cnt_q[i] <= wait_cnt_d[i];
      end
   end

   // Output stage control: load on grant, drain when consumed with nothing new.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_eop_q   <= 1'b0;
         out_grant_q <= '0;
         starve_q    <= 1'b0;
      end else begin
         starve_q <= grant_vld & starve_win;
         if (grant_vld) begin
            out_valid_q <= 1'b1;
            out_eop_q   <= bus.req_eop[grant_idx];
            out_grant_q <= grant_idx;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   // Payload register needs no reset; it is qualified by out_valid.
   always_ff @(posedge clk) begin
      if (grant_vld) out_data_q <= grant_data;
   end

   assign bus.req_ready  = grant_oh;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.out_eop    = out_eop_q;
   assign bus.out_grant  = out_grant_q;
   assign bus.starve_evt = starve_q;

endmodule

// File: tb/tb_vx_wb_sched.sv
// Bench for vx_wb_sched: two instances (STARVE_MAX 15 and 3) share one directed
// stimulus; each has its own behavioural model checked every cycle.
module tb_vx_wb_sched;

   localparam int unsigned N  = 5;
   localparam int unsigned DW = 16;
   localparam int unsigned IW = 3;

   logic              clk;
   logic              reset;
   logic [N-1:0]      req_valid;
   logic [N*DW-1:0]   req_data;
   logic [N-1:0]      req_eop;
   logic              out_ready;

   logic [N-1:0]      rr_ready [2];
   logic              ov [2];
   logic [DW-1:0]     od [2];
   logic              oe [2];
   logic [IW-1:0]     og [2];
   logic              se [2];

   int checks = 0;
   int errors = 0;
   int cyc_no = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int unsigned SM = (g == 0) ? 15 : 3;

      vx_wb_sched_if #(.NUM_REQS(N), .DATAW(DW)) bus ();

      assign bus.req_valid = req_valid;
      assign bus.req_data  = req_data;
      assign bus.req_eop   = req_eop;
      assign bus.out_ready = out_ready;
      assign rr_ready[g]   = bus.req_ready;
      assign ov[g]         = bus.out_valid;
      assign od[g]         = bus.out_data;
      assign oe[g]         = bus.out_eop;
      assign og[g]         = bus.out_grant;
      assign se[g]         = bus.starve_evt;

      vx_wb_sched #(
         .NUM_REQS   (N),
         .DATAW      (DW),
         .STARVE_MAX (SM),
         .LOCK_EOP   (1'b1)
      ) dut (
         .clk   (clk),
         .reset (reset),
         .bus   (bus)
      );

      // Model state: ages, last winner, packet owner (-1 = none), output beat.
      int            age [N];
      int            last;
      int            owner;
      bit            m_valid;
      logic [DW-1:0] m_data;
      bit            m_eop;
      int            m_grant;
      bit            m_starve;

      // Inputs are stable here; decide what the coming edge does, check, then advance.
      always @(negedge clk) begin
         int win;
         bit by_age;
         logic [N-1:0] exp_rdy;
         win    = -1;
         by_age = 1'b0;
         if (reset) begin
            for (int i = 0; i < int'(N); i++) age[i] = 0;
            last     = N - 1;
            owner    = -1;
            m_valid  = 1'b0;
            m_eop    = 1'b0;
            m_grant  = 0;
            m_starve = 1'b0;
            m_data   = '0;
         end else begin
            if (!m_valid || out_ready) begin
               if (owner >= 0) begin
                  if (req_valid[owner]) win = owner;
               end else begin
                  for (int i = 0; i < int'(N); i++)
                     if (win < 0 && req_valid[i] && age[i] == int'(SM)) begin
                        win    = i;
                        by_age = 1'b1;
                     end
                  for (int k = 1; k <= int'(N); k++)
                     if (win < 0 && req_valid[(last + k) % N]) win = (last + k) % N;
               end
            end
            exp_rdy = '0;
            if (win >= 0) exp_rdy[win] = 1'b1;
            chk($sformatf("inst%0d req_ready", g), rr_ready[g], exp_rdy);
            chk($sformatf("inst%0d out_valid", g), ov[g], m_valid);
            chk($sformatf("inst%0d starve_evt", g), se[g], m_starve);
            if (m_valid) begin
               chk($sformatf("inst%0d out_data", g), od[g], m_data);
               chk($sformatf("inst%0d out_eop", g), oe[g], m_eop);
               chk($sformatf("inst%0d out_grant", g), og[g], m_grant);
            end
            for (int i = 0; i < int'(N); i++) begin
               if (i == win || !req_valid[i]) age[i] = 0;
               else if (age[i] < int'(SM)) age[i] = age[i] + 1;
            end
            m_starve = by_age;
            if (win >= 0) begin
               last    = win;
               m_valid = 1'b1;
               m_data  = req_data[win*DW +: DW];
               m_eop   = req_eop[win];
               m_grant = win;
               owner   = req_eop[win] ? -1 : win;
            end else if (out_ready) begin
               m_valid = 1'b0;
            end
         end
      end
   end

   // Advance one edge; payloads are refreshed so every beat is distinguishable.
   task automatic step();
      @(posedge clk);
      #1;
      cyc_no++;
      for (int i = 0; i < int'(N); i++) req_data[i*DW +: DW] = {4'(i), 12'(cyc_no)};
   endtask

   int t1_exp [6] = '{0, 1, 2, 3, 4, 0};

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_eop   = '1;
      out_ready = 1'b1;
      req_data  = '0;
      repeat (3) step();
      for (int g = 0; g < 2; g++) begin
         chk("reset out_valid", ov[g], 1'b0);
         chk("reset out_grant", og[g], 0);
         chk("reset out_eop", oe[g], 1'b0);
         chk("reset starve_evt", se[g], 1'b0);
      end

      // T1: all valid, round robin from source 0
      reset     = 1'b0;
      req_valid = 5'b11111;
      for (int k = 0; k < 6; k++) begin
         step();
         chk($sformatf("t1 grant[%0d]", k), og[0], t1_exp[k]);
         chk("t1 out_valid", ov[0], 1'b1);
      end

      // T2: src1 three-beat packet is not interleaved
      req_valid = 5'b00111;
      req_eop   = 5'b11101;
      step(); chk("t2 beat0 grant", og[0], 1); chk("t2 beat0 eop", oe[0], 1'b0);
      step(); chk("t2 beat1 grant", og[0], 1); chk("t2 beat1 eop", oe[0], 1'b0);
      req_eop = '1;
      step(); chk("t2 beat2 grant", og[0], 1); chk("t2 beat2 eop", oe[0], 1'b1);
      req_valid = 5'b00101;
      step(); chk("t2 next grant", og[0], 2);
      step(); chk("t2 then grant", og[0], 0);

      // Idle drain
      req_valid = '0;
      step(); step();
      chk("idle out_valid i0", ov[0], 1'b0);
      chk("idle out_valid i1", ov[1], 1'b0);

      // T3: starvation across an output stall (instance 1 has STARVE_MAX=3)
      reset = 1'b1;
      step();
      reset     = 1'b0;
      req_valid = 5'b00001;
      out_ready = 1'b0;
      step(); chk("t3 pending grant", og[1], 0);
      req_valid = 5'b10000;
      repeat (4) step();
      #1 chk("t3 stalled ready", rr_ready[1], 5'b00000);
      chk("t3 held grant", og[1], 0);
      chk("t3 held valid", ov[1], 1'b1);
      out_ready = 1'b1;
      step();
      chk("t3 starve grant", og[1], 4);
      chk("t3 starve_evt set", se[1], 1'b1);
      chk("t3 no starve at 15", se[0], 1'b0);
      step();
      chk("t3 starve_evt clear", se[1], 1'b0);
      chk("t3 grant again", og[1], 4);

      // T4: src2 alone, out_ready toggling
      req_valid = 5'b00100;
      for (int k = 0; k < 4; k++) begin
         out_ready = (k % 2 == 0);
         #1;
         chk("t4 req_ready", rr_ready[0], out_ready ? 5'b00100 : 5'b00000);
         step();
         chk("t4 grant", og[0], 2);
         chk("t4 valid", ov[0], 1'b1);
      end

      // T5: locked owner goes quiet, others wait
      out_ready = 1'b1;
      req_valid = 5'b01000;
      req_eop   = 5'b10111;
      step(); chk("t5 lock grant", og[0], 3); chk("t5 lock eop", oe[0], 1'b0);
      req_valid = 5'b00001;
      req_eop   = '1;
      for (int k = 0; k < 2; k++) begin
         #1 chk("t5 blocked ready", rr_ready[0], 5'b00000);
         step();
         chk("t5 no beat", ov[0], 1'b0);
      end
      req_valid = 5'b01001;
      step(); chk("t5 owner eop grant", og[0], 3); chk("t5 owner eop", oe[0], 1'b1);
      req_valid = 5'b00001;
      step(); chk("t5 then src0", og[0], 0); chk("t5 then src0 i1", og[1], 0);

      // T6: reset while locked and stalled
      req_valid = 5'b00010;
      req_eop   = 5'b11101;
      step(); chk("t6 locked grant", og[0], 1);
      out_ready = 1'b0;
      reset     = 1'b1;
      step();
      chk("t6 reset out_valid", ov[0], 1'b0);
      chk("t6 reset out_grant", og[0], 0);
      reset     = 1'b0;
      out_ready = 1'b1;
      req_valid = 5'b01100;
      req_eop   = '1;
      step(); chk("t6 first grant", og[0], 2); chk("t6 first valid", ov[0], 1'b1);

      req_valid = '0;
      repeat (3) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
